// File: rtl/backlight_fader.sv
// backlight_fader: brightness ramp generator feeding the 8-bit duty input of
// the backlight PWM stage. A target level is accepted over a valid/ready
// handshake; the internal level then moves toward it by STEP once every
// PRESCALE clocks and is presented one cycle later as a registered duty word.
//
// Configuration macro: BL_GAMMA_EN
//   defined   : duty = (level*level + 255) >> 8 (square-law perceptual curve)
//   undefined : duty = level (no multiplier)
//
// Ports
//   clk            in   system clock
//   rst_n          in   asynchronous active-low reset
//   target_i       in   [7:0] requested brightness level
//   target_valid_i in   target_i is valid this cycle
//   target_ready_o out  fader can accept a target (IDLE only)
//   level_o        out  [7:0] current linear brightness level
//   duty_o         out  [7:0] duty word to the PWM stage, one cycle after level
//   busy_o         out  high while ramping
//   done_o         out  one-cycle pulse when level reaches the target
module backlight_fader #(
    parameter int unsigned PRESCALE    = 1000,
    parameter int unsigned STEP        = 1,
    parameter logic [7:0]  RESET_LEVEL = 8'd0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] target_i,
    input  logic       target_valid_i,
    output logic       target_ready_o,
    output logic [7:0] level_o,
    output logic [7:0] duty_o,
    output logic       busy_o,
    output logic       done_o
);

    localparam int unsigned LVL_W = 8;
    localparam int unsigned CNT_W = 16;
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(PRESCALE - 1);
    localparam logic [LVL_W:0]   STEP_X    = (LVL_W + 1)'(STEP);

    typedef enum logic {
        IDLE = 1'b0,
        RAMP = 1'b1
    } state_e;

    state_e           state_q;
    logic [LVL_W-1:0] level_q;
    logic [LVL_W-1:0] tgt_q;
    logic [LVL_W-1:0] duty_q;
    logic [CNT_W-1:0] tick_q;
    logic             done_q;

    logic [LVL_W:0]   up_c;
    logic [LVL_W:0]   dn_c;
    logic [LVL_W-1:0] level_d;

    // Level-to-duty transfer curve.
    function automatic logic [LVL_W-1:0] shape(input logic [LVL_W-1:0] x);
`ifdef BL_GAMMA_EN
        // 255*255 + 255 = 65280 still fits in 16 bits.
        return LVL_W'((16'(x) * 16'(x) + 16'd255) >> 8);
`else
        return x;
`endif
    endfunction

    // Next level on a tick: 9-bit sum/difference, clamped at the target so the
    // level can never overshoot or wrap past 0/255.
    always_comb begin
        up_c    = {1'b0, level_q} + STEP_X;
        dn_c    = {1'b0, level_q} - STEP_X;
        level_d = tgt_q;
        if (level_q < tgt_q) begin
            if (up_c < {1'b0, tgt_q}) begin
                level_d = up_c[LVL_W-1:0];
            end
        end else if (level_q > tgt_q) begin
            // dn_c[8] set means the subtraction borrowed below zero.
            if (!dn_c[LVL_W] && (dn_c[LVL_W-1:0] > tgt_q)) begin
                level_d = dn_c[LVL_W-1:0];
            end
        end
    end

    // Handshake, ramp FSM, tick counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            level_q <= RESET_LEVEL;
            tgt_q   <= RESET_LEVEL;
            duty_q  <= shape(RESET_LEVEL);
            tick_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            duty_q <= shape(level_q);
            case (state_q)
                IDLE: begin
                    if (target_valid_i && target_ready_o) begin
                        tgt_q <= target_i;
                        if (target_i != level_q) begin
                            state_q <= RAMP;
                            tick_q  <= '0;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                RAMP: begin
                    if (tick_q == TICK_LAST) begin
                        tick_q  <= '0;
                        level_q <= level_d;
                        // Landing step returns to IDLE on the same edge.
                        if (level_d == tgt_q) begin
                            state_q <= IDLE;
                            done_q  <= 1'b1;
                        end
                    end else begin
                        tick_q <= tick_q + CNT_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign target_ready_o = (state_q == IDLE);
    assign busy_o         = (state_q == RAMP);
    assign level_o        = level_q;
    assign duty_o         = duty_q;
    assign done_o         = done_q;

endmodule
